// File: rtl/mm_pkg.sv
// Shared types and default dimensions for the gains x states matrix-multiply sequencer.
package mm_pkg;

  localparam int MM_NUM_ROWS = 3;
  localparam int MM_NUM_COLS = 11;

  typedef logic [63:0] fp64_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } mm_state_e;

endpackage

// File: rtl/mm_sample_timer.sv
// Free-running sample timer: one tick per sample_time cycles while enabled.
module mm_sample_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] sample_time,
  output logic        tick
);

  logic [31:0] count_r;
  logic        tick_s;

  // Tick at the end of each period; a period of 0 or 1 ticks every cycle.
  // The >= also recovers when sample_time shrinks below the running count.
  always_comb begin
    tick_s = 1'b0;
    if (!enable) begin
      tick_s = 1'b0;
    end else if (sample_time <= 32'd1) begin
      tick_s = 1'b1;
    end else if (count_r >= (sample_time - 32'd1)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Period counter, held at zero while disabled and wrapped on each tick.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_r <= 32'd0;
    end else if (!enable || tick_s) begin
      count_r <= 32'd0;
    end else begin
      count_r <= count_r + 32'd1;
    end
  end

  assign tick = tick_s;

endmodule

// File: rtl/matrix_multiply_ctrl.sv
// Sequences one gains x states multiply per sample tick through a shared pipelined MAC
// and publishes the complete output vector once every row result has returned.
module matrix_multiply_ctrl
  import mm_pkg::*;
#(
  parameter int NUM_ROWS = MM_NUM_ROWS,
  parameter int NUM_COLS = MM_NUM_COLS,
  parameter int GIDX_W   = $clog2(NUM_ROWS * NUM_COLS),
  parameter int SIDX_W   = $clog2(NUM_COLS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [31:0]                  sample_time,
  output logic                         states_latch,
  output logic                         mac_valid,
  input  logic                         mac_ready,
  output logic                         mac_first,
  output logic                         mac_last,
  output logic [GIDX_W-1:0]            gain_idx,
  output logic [SIDX_W-1:0]            state_idx,
  input  logic                         mac_res_valid,
  input  logic [63:0]                  mac_res,
  output logic [NUM_ROWS-1:0][63:0]    output_matrix,
  output logic                         output_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int RIDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CNT_W  = $clog2(NUM_ROWS + 1);

  localparam logic [RIDX_W-1:0] LAST_ROW  = RIDX_W'(NUM_ROWS - 1);
  localparam logic [SIDX_W-1:0] LAST_TERM = SIDX_W'(NUM_COLS - 1);
  localparam logic [CNT_W-1:0]  ALL_ROWS  = CNT_W'(NUM_ROWS);

  mm_state_e                 state_r, state_s;
  logic [RIDX_W-1:0]         row_r, row_s;
  logic [SIDX_W-1:0]         term_r, term_s;
  logic [GIDX_W-1:0]         gidx_r, gidx_s;
  logic [CNT_W-1:0]          res_cnt_r, res_cnt_s;
  fp64_t [NUM_ROWS-1:0]      shadow_r, shadow_s;
  fp64_t [NUM_ROWS-1:0]      output_matrix_r;
  logic                      tick_s, hs_s, capture_s, done_s;
  logic                      states_latch_r, mac_valid_r, mac_first_r, mac_last_r;
  logic                      output_valid_r, busy_r, overrun_r;

  mm_sample_timer u_timer (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .sample_time (sample_time),
    .tick        (tick_s)
  );

  // Result capture into the shadow buffer; the published copy only moves on completion.
  always_comb begin
    capture_s = mac_res_valid && ((state_r == ISSUE) || (state_r == DRAIN))
                && (res_cnt_r < ALL_ROWS);
    res_cnt_s = res_cnt_r;
    shadow_s  = shadow_r;
    if (state_r == LATCH) begin
      res_cnt_s = {CNT_W{1'b0}};
    end else if (capture_s) begin
      res_cnt_s = res_cnt_r + 1'b1;
    end else begin
      res_cnt_s = res_cnt_r;
    end
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (capture_s && (res_cnt_r == CNT_W'(i))) begin
        shadow_s[i] = mac_res;
      end else begin
        shadow_s[i] = shadow_r[i];
      end
    end
    done_s = (state_r == DRAIN) && (res_cnt_s == ALL_ROWS);
  end

  // Sequencer next state and row-major index walk.
  always_comb begin
    state_s = state_r;
    row_s   = row_r;
    term_s  = term_r;
    gidx_s  = gidx_r;
    hs_s    = mac_valid_r && mac_ready;
    case (state_r)
      IDLE: begin
        if (tick_s) begin
          state_s = LATCH;
        end else begin
          state_s = IDLE;
        end
      end
      LATCH: begin
        state_s = ISSUE;
        row_s   = {RIDX_W{1'b0}};
        term_s  = {SIDX_W{1'b0}};
        gidx_s  = {GIDX_W{1'b0}};
      end
      ISSUE: begin
        if (!hs_s) begin
          state_s = ISSUE;
        end else if (term_r != LAST_TERM) begin
          term_s = term_r + 1'b1;
          gidx_s = gidx_r + 1'b1;
        end else if (row_r != LAST_ROW) begin
          term_s = {SIDX_W{1'b0}};
          row_s  = row_r + 1'b1;
          gidx_s = gidx_r + 1'b1;
        end else begin
          state_s = DRAIN;
          term_s  = {SIDX_W{1'b0}};
          row_s   = {RIDX_W{1'b0}};
          gidx_s  = {GIDX_W{1'b0}};
        end
      end
      DRAIN: begin
        if (done_s) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs are derived from next-state values
  // so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r         <= IDLE;
      row_r           <= {RIDX_W{1'b0}};
      term_r          <= {SIDX_W{1'b0}};
      gidx_r          <= {GIDX_W{1'b0}};
      res_cnt_r       <= {CNT_W{1'b0}};
      shadow_r        <= {(NUM_ROWS * 64){1'b0}};
      output_matrix_r <= {(NUM_ROWS * 64){1'b0}};
      states_latch_r  <= 1'b0;
      mac_valid_r     <= 1'b0;
      mac_first_r     <= 1'b0;
      mac_last_r      <= 1'b0;
      output_valid_r  <= 1'b0;
      busy_r          <= 1'b0;
      overrun_r       <= 1'b0;
    end else begin
      state_r         <= state_s;
      row_r           <= row_s;
      term_r          <= term_s;
      gidx_r          <= gidx_s;
      res_cnt_r       <= res_cnt_s;
      shadow_r        <= shadow_s;
      if (done_s) begin
        output_matrix_r <= shadow_s;
      end
      states_latch_r  <= (state_s == LATCH);
      mac_valid_r     <= (state_s == ISSUE);
      mac_first_r     <= (state_s == ISSUE) && (term_s == {SIDX_W{1'b0}});
      mac_last_r      <= (state_s == ISSUE) && (term_s == LAST_TERM);
      output_valid_r  <= done_s;
      busy_r          <= (state_s != IDLE);
      overrun_r       <= overrun_r || (tick_s && (state_r != IDLE));
    end
  end

  assign states_latch  = states_latch_r;
  assign mac_valid     = mac_valid_r;
  assign mac_first     = mac_first_r;
  assign mac_last      = mac_last_r;
  assign gain_idx      = gidx_r;
  assign state_idx     = term_r;
  assign output_matrix = output_matrix_r;
  assign output_valid  = output_valid_r;
  assign busy          = busy_r;
  assign overrun       = overrun_r;

endmodule

// File: tb/tb_matrix_multiply_ctrl.sv
// Directed bench for matrix_multiply_ctrl with a behavioural latency-4 MAC,
// gains 1..33 row-major and states 1..11.
module tb_matrix_multiply_ctrl;

  localparam int NR  = 3;
  localparam int NC  = 11;
  localparam int GW  = 6;
  localparam int SW  = 4;
  localparam int LAT = 4;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  enable;
  logic [31:0]           sample_time;
  logic                  states_latch, mac_valid, mac_ready, mac_first, mac_last;
  logic [GW-1:0]         gain_idx;
  logic [SW-1:0]         state_idx;
  logic                  mac_res_valid;
  logic [63:0]           mac_res;
  logic [NR-1:0][63:0]   output_matrix;
  logic                  output_valid, busy, overrun;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_row [NR];

  // MAC model and monitor state
  int cyc = 0, latch_cnt = 0, ov_cnt = 0;
  int latch_cyc = 0, last_spacing = 0, last_ov_cyc = -100, latch_gap = 0;
  int run_valid = 0, run_stalls = 0, first_issue_cyc = -1, last_hs_cyc = 0, last_res_cyc = -100;
  int exp_g = 0, exp_k = 0;
  bit ready_mode = 1'b0, tog = 1'b0, prev_stall = 1'b0, prev_ov = 1'b0;
  logic [GW-1:0] prev_g;
  logic [SW-1:0] prev_k;
  real acc = 0.0;
  int          due_q [$];
  logic [63:0] res_q [$];

  matrix_multiply_ctrl #(.NUM_ROWS(NR), .NUM_COLS(NC)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .sample_time   (sample_time),
    .states_latch  (states_latch),
    .mac_valid     (mac_valid),
    .mac_ready     (mac_ready),
    .mac_first     (mac_first),
    .mac_last      (mac_last),
    .gain_idx      (gain_idx),
    .state_idx     (state_idx),
    .mac_res_valid (mac_res_valid),
    .mac_res       (mac_res),
    .output_matrix (output_matrix),
    .output_valid  (output_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  initial forever #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Negedge monitor: output checks, run statistics and the behavioural MAC.
  initial begin
    mac_ready     = 1'b1;
    mac_res_valid = 1'b0;
    mac_res       = 64'd0;
    forever begin
      @(negedge clock);
      if (output_valid === 1'b1) begin
        ov_cnt++;
        for (int r = 0; r < NR; r++)
          check_eq($sformatf("row%0d", r), output_matrix[r], exp_row[r]);
        check_eq("ov_width", 64'(prev_ov), 64'd0);
        check_eq("ov_idle", 64'(busy), 64'd0);
        check_eq("ov_latency", 64'(cyc), 64'(last_res_cyc + 1));
        last_ov_cyc = cyc;
      end
      prev_ov = (output_valid === 1'b1);
      if (states_latch === 1'b1) begin
        if (latch_cnt > 0) last_spacing = cyc - latch_cyc;
        latch_gap = cyc - last_ov_cyc;
        latch_cyc = cyc;
        latch_cnt++;
        run_valid = 0; run_stalls = 0; first_issue_cyc = -1;
        exp_g = 0; exp_k = 0; tog = 1'b0; prev_stall = 1'b0;
      end
      if (reset !== 1'b1) begin
        due_q.delete();
        res_q.delete();
        mac_res_valid = 1'b0;
        mac_ready     = 1'b1;
        prev_stall    = 1'b0;
      end else begin
        mac_res_valid = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          mac_res_valid = 1'b1;
          mac_res       = res_q[0];
          void'(due_q.pop_front());
          void'(res_q.pop_front());
          last_res_cyc  = cyc;
        end
        if (ready_mode && mac_valid === 1'b1) begin
          mac_ready = tog;
          tog = ~tog;
        end else begin
          mac_ready = 1'b1;
        end
        if (mac_valid === 1'b1) begin
          run_valid++;
          if (first_issue_cyc < 0) first_issue_cyc = cyc;
          if (prev_stall) begin
            check_eq("hold_gain", 64'(gain_idx), 64'(prev_g));
            check_eq("hold_state", 64'(state_idx), 64'(prev_k));
          end
          if (mac_ready) begin
            check_eq("gain_idx", 64'(gain_idx), 64'(exp_g));
            check_eq("state_idx", 64'(state_idx), 64'(exp_k));
            check_eq("mac_first", 64'(mac_first), 64'(exp_k == 0));
            check_eq("mac_last", 64'(mac_last), 64'(exp_k == NC - 1));
            if (mac_first) acc = 0.0;
            acc = acc + real'(int'(gain_idx) + 1) * real'(int'(state_idx) + 1);
            if (mac_last) begin
              due_q.push_back(cyc + LAT);
              res_q.push_back($realtobits(acc));
            end
            last_hs_cyc = cyc;
            exp_g++;
            exp_k = (exp_k == NC - 1) ? 0 : exp_k + 1;
            prev_stall = 1'b0;
          end else begin
            run_stalls++;
            prev_stall = 1'b1;
            prev_g = gain_idx;
            prev_k = state_idx;
          end
        end else begin
          prev_stall = 1'b0;
        end
      end
      cyc++;
    end
  end

  initial begin
    int l0, o0, l5, o5;
    exp_row[0] = $realtobits(506.0);
    exp_row[1] = $realtobits(1232.0);
    exp_row[2] = $realtobits(1958.0);
    reset = 1'b0; enable = 1'b0; sample_time = 32'd100;

    // Reset state
    step(2);
    check_eq("rst_latch", 64'(states_latch), 64'd0);
    check_eq("rst_valid", 64'(mac_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_overrun", 64'(overrun), 64'd0);
    check_eq("rst_ov", 64'(output_valid), 64'd0);
    for (int r = 0; r < NR; r++) check_eq("rst_matrix", output_matrix[r], 64'd0);

    // 1: full computation
    reset = 1'b1; enable = 1'b1;
    for (int i = 0; i < 400 && ov_cnt < 1; i++) step(1);
    check_eq("s1_done", 64'(ov_cnt), 64'd1);
    check_eq("s1_latch_to_issue", 64'(first_issue_cyc), 64'(latch_cyc + 1));
    check_eq("s1_issues", 64'(run_valid), 64'd33);
    check_eq("s1_last_issue", 64'(last_hs_cyc), 64'(latch_cyc + 33));
    check_eq("s1_stalls", 64'(run_stalls), 64'd0);

    // 2: backpressure, output held during the run
    ready_mode = 1'b1;
    for (int i = 0; i < 200 && latch_cnt < 2; i++) step(1);
    step(20);
    check_eq("s2_hold_matrix", output_matrix[0], exp_row[0]);
    check_eq("s2_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 300 && ov_cnt < 2; i++) step(1);
    check_eq("s2_done", 64'(ov_cnt), 64'd2);
    check_eq("s2_issue_cycles", 64'(run_valid), 64'd66);
    check_eq("s2_stalls", 64'(run_stalls), 64'd33);
    ready_mode = 1'b0;

    // 3: period
    check_eq("s3_spacing_a", 64'(last_spacing), 64'd100);
    for (int i = 0; i < 200 && latch_cnt < 3; i++) step(1);
    check_eq("s3_spacing_b", 64'(last_spacing), 64'd100);
    for (int i = 0; i < 200 && ov_cnt < 3; i++) step(1);
    check_eq("s3_overrun", 64'(overrun), 64'd0);

    // 4: overrun with a 10-cycle period
    enable = 1'b0;
    step(2);
    sample_time = 32'd10;
    l0 = latch_cnt; o0 = ov_cnt;
    enable = 1'b1;
    step(150);
    check_eq("s4_overrun_set", 64'(overrun), 64'd1);
    step(100);
    check_eq("s4_overrun_sticky", 64'(overrun), 64'd1);
    check_eq("s4_spacing", 64'(last_spacing), 64'd40);
    enable = 1'b0;
    for (int i = 0; i < 200 && busy !== 1'b0; i++) step(1);
    step(2);
    check_eq("s4_idle", 64'(busy), 64'd0);
    check_eq("s4_ov_count", 64'(ov_cnt - o0), 64'(latch_cnt - l0));
    check_eq("s4_overrun_end", 64'(overrun), 64'd1);

    // 5: reset in the 10th ISSUE cycle
    sample_time = 32'd100;
    l0 = latch_cnt;
    enable = 1'b1;
    for (int i = 0; i < 200 && latch_cnt == l0; i++) step(1);
    for (int i = 0; i < 50 && run_valid < 9; i++) step(1);
    check_eq("s5_mid_issue", 64'(mac_valid), 64'd1);
    reset = 1'b0;
    o5 = ov_cnt;
    step(1);
    check_eq("s5_latch", 64'(states_latch), 64'd0);
    check_eq("s5_valid", 64'(mac_valid), 64'd0);
    check_eq("s5_busy", 64'(busy), 64'd0);
    check_eq("s5_overrun", 64'(overrun), 64'd0);
    check_eq("s5_ov", 64'(output_valid), 64'd0);
    check_eq("s5_gain_idx", 64'(gain_idx), 64'd0);
    for (int r = 0; r < NR; r++) check_eq("s5_matrix", output_matrix[r], 64'd0);
    reset = 1'b1;
    l5 = latch_cnt;
    for (int i = 0; i < 300 && ov_cnt == o5; i++) step(1);
    check_eq("s5_one_result", 64'(ov_cnt - o5), 64'd1);
    check_eq("s5_no_stale", 64'(latch_cnt - l5), 64'd1);

    // 6: zero period, then enable drop mid-ISSUE
    sample_time = 32'd0;
    o0 = ov_cnt;
    for (int i = 0; i < 300 && ov_cnt < o0 + 2; i++) step(1);
    step(1);
    check_eq("s6_gap", 64'(latch_gap), 64'd1);
    check_eq("s6_spacing", 64'(last_spacing), 64'd39);
    for (int i = 0; i < 50 && run_valid < 5; i++) step(1);
    enable = 1'b0;
    l0 = latch_cnt; o0 = ov_cnt;
    for (int i = 0; i < 200 && ov_cnt == o0; i++) step(1);
    step(50);
    check_eq("s6_completed", 64'(ov_cnt - o0), 64'd1);
    check_eq("s6_no_latch", 64'(latch_cnt), 64'(l0));
    check_eq("s6_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
